// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, update visible next cycle.
// No backpressure; optional same-cycle update forwarding to lookup via BTB_BYPASS_EN.
module branch_target_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int INDEX_BITS = 3,
  localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [ADDR_WIDTH-1:0] target;
    logic [1:0]            ctr;
  } entry_t;

  entry_t table_q [DEPTH];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  entry_t                upd_entry;
  entry_t                new_entry;
  entry_t                lk_entry;
  logic                  upd_hit;
  logic                  upd_write;
  logic                  unused_pc_lsb;

  // Halfword-aligned PCs: bit 0 carries no information.
  assign lk_idx        = lookup_pc[INDEX_BITS:1];
  assign lk_tag        = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+1];
  assign upd_idx       = upd_pc[INDEX_BITS:1];
  assign upd_tag       = upd_pc[ADDR_WIDTH-1:INDEX_BITS+1];
  assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  always_comb begin
    new_entry = upd_entry;
    upd_write = 1'b0;
    if (upd_valid && enable && !flush) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken) begin
          new_entry.ctr    = (upd_entry.ctr == 2'b11) ? 2'b11 : upd_entry.ctr + 2'd1;
          new_entry.target = upd_target;
        end else begin
          new_entry.ctr = (upd_entry.ctr == 2'b00) ? 2'b00 : upd_entry.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        upd_write        = 1'b1;
        new_entry.valid  = 1'b1;
        new_entry.tag    = upd_tag;
        new_entry.target = upd_target;
        new_entry.ctr    = 2'b10;
      end
    end
  end

  // Flush only clears valid bits; tag/target/ctr history is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].ctr    <= 2'b01;
      end
    end else if (enable && flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (upd_write) begin
      table_q[upd_idx] <= new_entry;
    end
  end

  always_comb begin
    lk_entry = table_q[lk_idx];
`ifdef BTB_BYPASS_EN
    if (upd_write && !rst && (upd_idx == lk_idx)) begin
      lk_entry = new_entry;
    end
`endif
  end

  assign hit            = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign predict_taken  = hit && lk_entry.ctr[1];
  assign predict_target = hit ? lk_entry.target : '0;

endmodule
